// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues one imem word fetch per cycle and buffers responses in a FIFO for decode.
// Optional IF_MISALIGN_CHK_EN: a misaligned redirect halts fetch and queues a single misaligned-fetch marker entry.
module if_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              ADDR_W   = 30,
    parameter int              FQ_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [XLEN-1:0]   imem_rdata,
    output logic              fq_valid,
    input  logic              fq_ready,
    output logic [XLEN-1:0]   fq_pc,
    output logic [XLEN-1:0]   fq_pc_plus4,
    output logic [XLEN-1:0]   fq_instr,
    output logic              fq_misalign
);

    localparam int                PTR_W     = $clog2(FQ_DEPTH);
    localparam int                CNT_W     = PTR_W + 1;
    localparam logic [CNT_W:0]    DEPTH_OCC = (CNT_W + 1)'(FQ_DEPTH);
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(FQ_DEPTH);
    localparam logic [XLEN-1:0]   NOP_INSTR = XLEN'(32'h0000_0013);

    logic [XLEN-1:0]  r_pc;
    logic             r_inflight;
    logic [XLEN-1:0]  r_inflight_pc;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic [XLEN-1:0]  r_fq_pc    [FQ_DEPTH];
    logic [XLEN-1:0]  r_fq_instr [FQ_DEPTH];

    logic             w_pop;
    logic             w_push;
    logic             w_issue;
    logic             w_halted;
    logic             w_mis_pend;
    logic [XLEN-1:0]  w_redirect_tgt;
    logic [XLEN-1:0]  w_push_instr;
    logic [CNT_W:0]   w_occupancy;

`ifdef IF_MISALIGN_CHK_EN
    logic r_halted;
    logic r_mis_pend;
    logic r_fq_mis [FQ_DEPTH];

    assign w_halted       = r_halted;
    assign w_mis_pend     = r_mis_pend;
    assign w_redirect_tgt = redirect_pc;
    assign fq_misalign    = fq_valid & r_fq_mis[r_rd_ptr];

    // The marker entry is queued one cycle after the redirect, mimicking a fetch response slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_halted   <= 1'b0;
            r_mis_pend <= 1'b0;
        end else if (redirect_valid) begin
            r_halted   <= |redirect_pc[1:0];
            r_mis_pend <= |redirect_pc[1:0];
        end else begin
            r_mis_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fq_mis[r_wr_ptr] <= w_mis_pend;
        end
    end
`else
    logic w_unused_lo;

    assign w_unused_lo    = ^redirect_pc[1:0];
    assign w_halted       = 1'b0;
    assign w_mis_pend     = 1'b0;
    assign w_redirect_tgt = {redirect_pc[XLEN-1:2], 2'b00};
    assign fq_misalign    = 1'b0;
`endif

    assign fq_valid     = (r_count != '0);
    assign w_pop        = fq_valid & fq_ready;
    assign w_push       = (r_inflight | w_mis_pend) & ~redirect_valid;
    assign w_push_instr = w_mis_pend ? NOP_INSTR : imem_rdata;

    // Reserve a slot for the in-flight response so a full queue never overflows.
    assign w_occupancy = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight} - {{CNT_W{1'b0}}, w_pop};
    assign w_issue     = reset & ~redirect_valid & ~w_halted & (w_occupancy < DEPTH_OCC);

    assign imem_en     = w_issue;
    assign imem_addr   = r_pc[ADDR_W+1:2];
    assign fq_pc       = r_fq_pc[r_rd_ptr];
    assign fq_instr    = r_fq_instr[r_rd_ptr];
    assign fq_pc_plus4 = fq_pc + XLEN'(4);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= RESET_PC;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
        end else if (redirect_valid) begin
            r_pc          <= w_redirect_tgt;
            r_inflight    <= 1'b0;
            r_inflight_pc <= w_redirect_tgt;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= r_pc;
                r_pc          <= r_pc + XLEN'(4);
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fq_pc[r_wr_ptr]    <= r_inflight_pc;
            r_fq_instr[r_wr_ptr] <= w_push_instr;
        end
    end

    a_no_pop_empty: assert property (@(posedge clk) disable iff (!reset)
        !(w_pop && (r_count == '0)));
    a_no_push_full: assert property (@(posedge clk) disable iff (!reset)
        !(w_push && !w_pop && (r_count == DEPTH_CNT)));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed start-up/backpressure/redirect/reset scenarios plus random traffic,
// checked against a stream-level model (expected PC sequence restarted on every redirect or reset).
module tb_if_fetch_unit;

    localparam int          XLEN     = 32;
    localparam int          ADDR_W   = 30;
    localparam int          FQ_DEPTH = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    localparam int M_NORM = 0;
    localparam int M_MIS  = 1;
    localparam int M_HALT = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_pc;
    logic              imem_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [XLEN-1:0]   imem_rdata = '0;
    logic              fq_valid;
    logic              fq_ready;
    logic [XLEN-1:0]   fq_pc;
    logic [XLEN-1:0]   fq_pc_plus4;
    logic [XLEN-1:0]   fq_instr;
    logic              fq_misalign;

    int checks = 0;
    int errors = 0;
    int mode   = M_NORM;
    int stall  = 0;
    logic [XLEN-1:0] exp_q[$];
    logic [XLEN-1:0] last_fetch = '0;

    // clock / reset block
    always #5 clk = ~clk;

    if_fetch_unit #(
        .XLEN(XLEN), .ADDR_W(ADDR_W), .FQ_DEPTH(FQ_DEPTH), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .fq_valid(fq_valid), .fq_ready(fq_ready),
        .fq_pc(fq_pc), .fq_pc_plus4(fq_pc_plus4), .fq_instr(fq_instr),
        .fq_misalign(fq_misalign)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // synchronous instruction memory, 1-cycle latency
    always @(posedge clk) begin
        if (imem_en) begin
            imem_rdata <= instr_of({imem_addr, 2'b00});
            last_fetch <= {imem_addr, 2'b00};
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock of stimulus; checks the queue head against the model, then advances the model.
    task automatic cycle(input logic rdy, input logic redir, input logic [31:0] tgt);
        logic        popped;
        logic [31:0] p;
        fq_ready       = rdy;
        redirect_valid = redir;
        redirect_pc    = tgt;
        #1;
        if (mode != M_NORM && !redir) check("halt_imem_en", 32'(imem_en), 32'd0);
        popped = fq_valid & rdy;
        if (fq_valid) begin
            if (mode == M_NORM) begin
                check("head_pc", fq_pc, exp_q[0]);
                check("head_instr", fq_instr, instr_of(exp_q[0]));
                check("head_pc4", fq_pc_plus4, exp_q[0] + 32'd4);
                check("head_mis", 32'(fq_misalign), 32'd0);
            end else if (mode == M_MIS) begin
                check("mis_pc", fq_pc, exp_q[0]);
                check("mis_instr", fq_instr, 32'h0000_0013);
                check("mis_flag", 32'(fq_misalign), 32'd1);
            end else begin
                check("halt_valid", 32'(fq_valid), 32'd0);
            end
        end
        if (popped) begin
            if (mode == M_NORM) begin
                p = exp_q.pop_front();
                exp_q.push_back(p + 32'd4);
            end else if (mode == M_MIS) begin
                mode = M_HALT;
            end
        end
        if (redir) begin
            exp_q.delete();
            stall = 0;
`ifdef IF_MISALIGN_CHK_EN
            exp_q.push_back(tgt);
            mode = (tgt[1:0] != 2'b00) ? M_MIS : M_NORM;
`else
            exp_q.push_back({tgt[31:2], 2'b00});
            mode = M_NORM;
`endif
        end else if (rdy && mode == M_NORM) begin
            stall = popped ? 0 : stall + 1;
            check("stall_bound", 32'(stall <= 3), 32'd1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_and_start();
        @(posedge clk);
        #1;
        reset          = 1'b0;
        fq_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        #1;
        check("rst_fq_valid", 32'(fq_valid), 32'd0);
        check("rst_imem_en", 32'(imem_en), 32'd0);
        check("rst_imem_addr", 32'(imem_addr), RESET_PC >> 2);
        check("rst_misalign", 32'(fq_misalign), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("start_imem_en", 32'(imem_en), 32'd1);
        check("start_imem_addr", 32'(imem_addr), RESET_PC >> 2);
        @(posedge clk);
        #1;
        check("start_c1_valid", 32'(fq_valid), 32'd0);
        @(posedge clk);
        #1;
        check("start_c2_valid", 32'(fq_valid), 32'd1);
        exp_q.delete();
        exp_q.push_back(RESET_PC);
        mode  = M_NORM;
        stall = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        logic        rdy;
        logic        redir;
        logic [31:0] tgt;
        reset          = 1'b0;
        fq_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        reset_and_start();

        // sustained throughput with fq_ready high
        repeat (20) begin
            cycle(1'b1, 1'b0, 32'd0);
            check("thruput_valid", 32'(fq_valid), 32'd1);
        end

        // backpressure: queue fills and fetching stops
        repeat (10) cycle(1'b0, 1'b0, 32'd0);
        fq_ready = 1'b0;
        #1;
        check("fill_imem_en", 32'(imem_en), 32'd0);
        check("fill_entries", ((last_fetch - exp_q[0]) >> 2) + 32'd1, 32'(FQ_DEPTH));
        repeat (8) begin
            cycle(1'b1, 1'b0, 32'd0);
            check("drain_valid", 32'(fq_valid), 32'd1);
        end

        // redirect while the queue is full
        repeat (6) cycle(1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b1, 32'h100);
        check("redir_n1_valid", 32'(fq_valid), 32'd0);
        fq_ready       = 1'b1;
        redirect_valid = 1'b0;
        #1;
        check("redir_fetch_en", 32'(imem_en), 32'd1);
        check("redir_fetch_addr", 32'(imem_addr), 32'h100 >> 2);
        cycle(1'b1, 1'b0, 32'd0);
        check("redir_n2_valid", 32'(fq_valid), 32'd0);
        cycle(1'b1, 1'b0, 32'd0);
        check("redir_n3_valid", 32'(fq_valid), 32'd1);
        check("redir_n3_pc", fq_pc, 32'h100);
        repeat (6) cycle(1'b1, 1'b0, 32'd0);

        // back-to-back redirects: only the second stream may emerge
        cycle(1'b1, 1'b1, 32'h200);
        cycle(1'b1, 1'b1, 32'h300);
        repeat (10) cycle(1'b1, 1'b0, 32'd0);

        // reset mid-stream
        repeat (5) cycle(1'b1, 1'b0, 32'd0);
        reset_and_start();
        repeat (8) cycle(1'($urandom_range(0, 1)), 1'b0, 32'd0);

        // misaligned redirect
        cycle(1'b1, 1'b1, 32'h102);
        repeat (6) cycle(1'b1, 1'b0, 32'd0);
`ifdef IF_MISALIGN_CHK_EN
        check("mis_entry_popped", 32'(mode == M_HALT), 32'd1);
        check("mis_halt_valid", 32'(fq_valid), 32'd0);
        cycle(1'b1, 1'b1, 32'h400);
        repeat (6) cycle(1'b1, 1'b0, 32'd0);
        check("resume_valid", 32'(fq_valid), 32'd1);
`else
        check("aligned_resume_valid", 32'(fq_valid), 32'd1);
`endif

        // random traffic
        repeat (400) begin
            rdy   = ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 19) == 0);
            tgt   = $urandom_range(0, 1023) << 2;
            if ($urandom_range(0, 3) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
            cycle(rdy, redir, tgt);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
